// File: rtl/pu_feed_pkg.sv
// pu_feed_pkg: shared constants and FSM state type for the PU feeder.
package pu_feed_pkg;

  localparam int unsigned DW         = 5;
  localparam int unsigned N_LANES    = 4;
  localparam int unsigned IDX_W      = $clog2(N_LANES);
  localparam int unsigned PU_LAT_DEF = 1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/pu_feed_lanes.sv
// pu_feed_lanes: N_LANES x DW register bank with indexed write.
// With zfill_i set, every lane above the written index is cleared on the
// same edge (used to close a short vector).
module pu_feed_lanes
  import pu_feed_pkg::*;
#(
  parameter int unsigned DW = pu_feed_pkg::DW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic [DW-1:0]                wr_data_i,
  input  logic                         zfill_i,
  output logic [N_LANES-1:0][DW-1:0]   lanes_o
);

  logic [N_LANES-1:0][DW-1:0] lanes_q, lanes_d;

  // Next lane contents: write the selected lane, optionally zero the ones above.
  always_comb begin
    lanes_d = lanes_q;
    if (wr_en_i) begin
      for (int unsigned i = 0; i < N_LANES; i++) begin
        if (i == 32'(wr_idx_i)) begin
          lanes_d[i] = wr_data_i;
        end else if (zfill_i && (i > 32'(wr_idx_i))) begin
          lanes_d[i] = '0;
        end
      end
    end
  end

  // Lane storage, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_q <= '0;
    end else begin
      lanes_q <= lanes_d;
    end
  end

  assign lanes_o = lanes_q;

endmodule

// File: rtl/pu_feed_seq.sv
// pu_feed_seq: serial-to-lane feeder for the 4-lane PU.
// Packs four accepted activations into x1..x4, holds weights w1..w4,
// waits PU_LAT cycles and captures pu_out into a handshaked result register.
// Optional feature macro: PU_FEED_FLUSH_EN (adds in_last for short vectors).
module pu_feed_seq
  import pu_feed_pkg::*;
#(
  parameter int unsigned DW     = pu_feed_pkg::DW,
  parameter int unsigned PU_LAT = PU_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
`ifdef PU_FEED_FLUSH_EN
  input  logic          in_last,
`endif
  output logic          in_ready,
  input  logic          w_load,
  input  logic [1:0]    w_addr,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic [DW-1:0] x4,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic [DW-1:0] w3,
  output logic [DW-1:0] w4,
  output logic          vec_valid,
  input  logic [DW-1:0] pu_out,
  output logic [DW-1:0] res_data,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int unsigned CW = (PU_LAT > 1) ? $clog2(PU_LAT) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic              in_ready_q, in_ready_d;
  logic              w_ready_q, w_ready_d;
  logic              vec_valid_q, vec_valid_d;
  logic              res_valid_q, res_valid_d;
  logic [DW-1:0]     res_q, res_d;

  logic              acc;
  logic              acc_last;
  logic              zfill;
  logic              w_wr;

  logic [N_LANES-1:0][DW-1:0] x_lanes;
  logic [N_LANES-1:0][DW-1:0] w_lanes;

  // The registered ready flags double as the acceptance gates; they track
  // state FILL except during the first cycle after reset release.
  assign acc  = in_valid & in_ready_q;
  assign w_wr = w_load & w_ready_q;

`ifdef PU_FEED_FLUSH_EN
  assign zfill    = in_last;
  assign acc_last = acc & (in_last | (cnt_q == IDX_W'(N_LANES - 1)));
`else
  assign zfill    = 1'b0;
  assign acc_last = acc & (cnt_q == IDX_W'(N_LANES - 1));
`endif

  // Next-state and next-output computation for the feeder FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    res_d   = res_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          if (acc_last) begin
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        wait_d  = CW'(PU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          res_d   = pu_out;
          state_d = HOLD;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    in_ready_d  = (state_d == FILL);
    w_ready_d   = (state_d == FILL);
    vec_valid_d = (state_d == ISSUE);
    res_valid_d = (state_d == HOLD);
  end

  // FSM state, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      vec_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      in_ready_q  <= in_ready_d;
      w_ready_q   <= w_ready_d;
      vec_valid_q <= vec_valid_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  pu_feed_lanes #(.DW(DW)) u_x_lanes (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (acc),
    .wr_idx_i  (cnt_q),
    .wr_data_i (in_data),
    .zfill_i   (zfill),
    .lanes_o   (x_lanes)
  );

  pu_feed_lanes #(.DW(DW)) u_w_lanes (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (w_wr),
    .wr_idx_i  (w_addr),
    .wr_data_i (w_data),
    .zfill_i   (1'b0),
    .lanes_o   (w_lanes)
  );

  assign x1 = x_lanes[0];
  assign x2 = x_lanes[1];
  assign x3 = x_lanes[2];
  assign x4 = x_lanes[3];
  assign w1 = w_lanes[0];
  assign w2 = w_lanes[1];
  assign w3 = w_lanes[2];
  assign w4 = w_lanes[3];

  assign in_ready  = in_ready_q;
  assign w_ready   = w_ready_q;
  assign vec_valid = vec_valid_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_pu_feed_seq.sv
// tb_pu_feed_seq: scoreboard bench for pu_feed_seq with a PU stub.
module tb_pu_feed_seq;
  import pu_feed_pkg::*;

  localparam int unsigned LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       w_load;
  logic [1:0] w_addr;
  logic [4:0] w_data;
  logic       w_ready;
  logic [4:0] x1, x2, x3, x4, w1, w2, w3, w4;
  logic       vec_valid;
  logic [4:0] pu_out;
  logic [4:0] res_data;
  logic       res_valid;
  logic       res_ready;
`ifdef PU_FEED_FLUSH_EN
  logic       in_last = 1'b0;
`endif

  pu_feed_seq #(.DW(5), .PU_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef PU_FEED_FLUSH_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .w_load    (w_load),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .x4        (x4),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .w4        (w4),
    .vec_valid (vec_valid),
    .pu_out    (pu_out),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // PU stub: result = 1 + sum(x) - sum(w) mod 32 (17 for x=5..8, w=1..4),
  // delayed through LAT register stages.
  function automatic logic [4:0] pu_f(input logic [19:0] xs, input logic [19:0] ws);
    logic [4:0] s;
    s = 5'd1;
    for (int i = 0; i < 4; i++) s = s + xs[i*5 +: 5] - ws[i*5 +: 5];
    return s;
  endfunction

  logic [4:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= pu_f({x4, x3, x2, x1}, {w4, w3, w2, w1});
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pu_out = pipe[LAT-1];

  // Scoreboard
  typedef struct packed {
    logic [19:0] x;
    logic [19:0] w;
  } vec_t;

  vec_t       vq[$];
  logic [4:0] rq[$];
  logic [4:0] xm[4];
  logic [4:0] wm[4];
  int         cntm = 0;
  int unsigned acc_cyc;
  vec_t       mon_e;

  task automatic push_exp();
    vec_t v;
    v.x = {xm[3], xm[2], xm[1], xm[0]};
    v.w = {wm[3], wm[2], wm[1], wm[0]};
    vq.push_back(v);
    rq.push_back(pu_f(v.x, v.w));
  endtask

  // Drive one sample and wait for its acceptance; in_valid stays high.
  task automatic send(input logic [4:0] d, input logic last);
    bit ok;
    ok = 0;
    in_data  = d;
    in_valid = 1'b1;
`ifdef PU_FEED_FLUSH_EN
    in_last  = last;
`endif
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      chk("send_timeout", 0, 1);
    end else begin
      acc_cyc = cyc;
      xm[cntm] = d;
      if (last || cntm == 3) begin
        for (int j = cntm + 1; j < 4; j++) xm[j] = 5'd0;
        push_exp();
        cntm = 0;
      end else begin
        cntm++;
      end
    end
`ifdef PU_FEED_FLUSH_EN
    in_last = 1'b0;
`endif
  endtask

  task automatic wwrite(input logic [1:0] a, input logic [4:0] d);
    w_load = 1'b1;
    w_addr = a;
    w_data = d;
    @(posedge clk);
    #1;
    w_load = 1'b0;
  endtask

  // Monitor: compare issued vectors and handshaked results against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (vec_valid) begin
        if (vq.size() == 0) begin
          chk("vec_unexpected", 1, 0);
        end else begin
          mon_e = vq.pop_front();
          chk("vec_x", {12'd0, x4, x3, x2, x1}, {12'd0, mon_e.x});
          chk("vec_w", {12'd0, w4, w3, w2, w1}, {12'd0, mon_e.w});
        end
      end
      if (res_valid && res_ready) begin
        if (rq.size() == 0) chk("res_unexpected", 1, 0);
        else                chk("res_data", {27'd0, res_data}, {27'd0, rq.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit          stable;
    int unsigned t0[3];
    in_valid = 0; in_data = 0; w_load = 0; w_addr = 0; w_data = 0; res_ready = 0;
    for (int i = 0; i < 4; i++) begin xm[i] = 0; wm[i] = 0; end

    // Reset state
    #12;
    chk("rst_x", {x4, x3, x2, x1}, 0);
    chk("rst_w", {w4, w3, w2, w1}, 0);
    chk("rst_flags", {vec_valid, res_valid, in_ready, w_ready}, 0);
    chk("rst_res", res_data, 0);
    @(negedge clk); rst = 1'b1;
    #1 chk("rel_in_ready_pre", in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_w_ready", w_ready, 1);

    // res_ready with no result pending does nothing
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_res_ready", {res_valid, in_ready}, 2'b01);
    res_ready = 1'b0;

    // Weights, with a repeated write to lane 0
    wwrite(2'd0, 5'd30); wwrite(2'd0, 5'd1);
    wwrite(2'd1, 5'd2);  wwrite(2'd2, 5'd3); wwrite(2'd3, 5'd4);
    wm[0] = 1; wm[1] = 2; wm[2] = 3; wm[3] = 4;
    chk("w_last_wins", w1, 1);

    // Basic vector and latency
    send(5'd5, 0); send(5'd6, 0); send(5'd7, 0); send(5'd8, 0);
    in_valid = 1'b0;
    chk("issue_vec_valid", vec_valid, 1);
    chk("issue_ready", {in_ready, w_ready, res_valid}, 0);
    @(posedge clk); #1;
    chk("wait_flags", {vec_valid, res_valid}, 0);
    @(posedge clk); #1;
    chk("hold_res_valid", res_valid, 1);
    chk("hold_res_data", res_data, 17);

    // Backpressure
    stable = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!(res_valid && res_data == 5'd17 && !in_ready && !w_ready)) stable = 0;
    end
    chk("bp_stable", stable, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_res_valid", res_valid, 0);

    // Weight write on the fourth-accept edge, then a dropped write in HOLD
    send(5'd1, 0); send(5'd2, 0); send(5'd3, 0);
    w_load = 1'b1; w_addr = 2'd1; w_data = 5'd9; wm[1] = 9;
    send(5'd4, 0);
    w_load = 1'b0; in_valid = 1'b0;
    chk("same_edge_w2", w2, 9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_w_ready", w_ready, 0);
    wwrite(2'd2, 5'd21);
    chk("hold_w3_kept", w3, 3);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;

    // Reset mid-vector
    send(5'd10, 0); send(5'd11, 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_x", {x4, x3, x2, x1}, 0);
    chk("mid_rst_w", {w4, w3, w2, w1}, 0);
    chk("mid_rst_flags", {vec_valid, res_valid, in_ready, w_ready}, 0);
    for (int i = 0; i < 4; i++) wm[i] = 0;
    cntm = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_in_ready", in_ready, 1);
    send(5'd1, 0); send(5'd1, 0); send(5'd1, 0); send(5'd1, 0);
    in_valid = 1'b0;
    chk("ones_vec_valid", vec_valid, 1);
    chk("ones_x", {x4, x3, x2, x1}, {5'd1, 5'd1, 5'd1, 5'd1});

    // Back-to-back vectors, in_valid held high, result always accepted
    res_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 4; i++) begin
        send(5'(v * 4 + i + 2), 0);
        if (i == 0) t0[v] = acc_cyc;
      end
    end
    in_valid = 1'b0;
    chk("b2b_period0", t0[1] - t0[0], 7);
    chk("b2b_period1", t0[2] - t0[1], 7);

`ifdef PU_FEED_FLUSH_EN
    // Short vector closed by in_last
    send(5'd3, 0); send(5'd4, 1);
    in_valid = 1'b0;
    chk("flush_vec_valid", vec_valid, 1);
    chk("flush_x", {x4, x3, x2, x1}, {5'd0, 5'd0, 5'd4, 5'd3});
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("vq_drained", vq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
